ulpi_reg_sched: RTL
===================

Name: ulpi_reg_sched

Overview:
- Link-side scheduler for ULPI PHY register access.
- Arbitrates two requesters, A (init sequencer) and B (debug/host), round-robin, and sequences the selected register write or read on the shared ULPI bus.
- Handles DIR turnaround, NXT throttling, STP generation, PHY-initiated aborts with retry, and captures unsolicited RX CMD bytes.
- Sits between requesters and ulpi_ctrl's bus pins; its o_data feeds the top-level tristate (driven only when DIR=0).

Parameters:
- MAX_RETRY, 3, abort retries per transaction before completing with error.
- RR_INIT, 0, initial round-robin priority (0 = A first).

Ports:
- i_clk  in  1  ULPI_CLK domain, 60 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_dir  in  1  PHY DIR.
- i_nxt  in  1  PHY NXT.
- i_data  in  8  ULPI data from PHY.
- o_data  out  8  ULPI data to PHY; 0x00 (NOOP) whenever not transmitting.
- o_stp  out  1  ULPI STP.
- i_a_valid / i_b_valid  in  1  request pending; held until ready.
- i_a_we / i_b_we  in  1  1 = write, 0 = read.
- i_a_addr / i_b_addr  in  6  immediate register address.
- i_a_wdata / i_b_wdata  in  8  write data.
- o_a_ready / o_b_ready  out  1  one-cycle grant pulse; request latched internally.
- o_a_done / o_b_done  out  1  one-cycle completion pulse.
- o_rdata  out  8  read result, valid with done; holds until next done.
- o_err  out  1  valid with done; 1 = retries exhausted.
- o_rxcmd_valid  out  1  one-cycle pulse on captured RX CMD.
- o_rxcmd  out  8  last RX CMD byte.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; o_data=0; o_stp=0; all ready/done/err/rxcmd_valid=0; o_rdata=0; o_rxcmd=0; retry count=0; rr pointer=RR_INIT. Reset mid-transaction abandons it immediately with no done pulse.
- IDLE:
  - If i_dir=0 and any valid: grant per rr pointer (if both are valid, the pointer wins; pointer then flips to the other requester).
  - Assert the matching ready for 1 cycle, latch we/addr/wdata, go to TXCMD next cycle.
  - If i_dir=1, no grant is issued.
- TXCMD: o_data = {2'b10,addr} for a write, {2'b11,addr} for a read.
  - Held until i_nxt=1 && i_dir=0 is sampled; then write → WDATA, read → RD_WAIT.
- WDATA: o_data=wdata, held until i_nxt=1 && i_dir=0 is sampled; then → STP.
- STP: o_stp=1 and o_data=0 for exactly 1 cycle; done pulses the same cycle, err=0; → IDLE.
- RD_WAIT: o_data=0. On the first cycle with i_dir=1 (turnaround; i_data ignored) → RD_DATA.
- RD_DATA:
  - Next cycle: if i_nxt=0, capture i_data into o_rdata, pulse done (err=0), → RD_END.
  - If i_nxt=1, treat as abort (PHY started a USB receive) → ABORT.
- RD_END: wait for i_dir=0, then one turnaround cycle with o_data=0, then → IDLE.
- Abort: i_dir=1 sampled in TXCMD or WDATA → ABORT.
  - ABORT: o_data=0, o_stp=0; wait for i_dir=0, then one turnaround cycle.
  - Then, if retry count < MAX_RETRY: increment it and reissue from TXCMD with the same latched request.
  - Otherwise: pulse done with err=1 and o_rdata unchanged → IDLE.
  - Retry count clears on every grant.
- RX CMD capture: in any state except RD_DATA, after a DIR rising turnaround, every cycle with i_dir=1 && i_nxt=0 latches i_data into o_rxcmd and pulses o_rxcmd_valid. Cycles with i_nxt=1 (packet data) are ignored.
- o_stp is never asserted while i_dir=1.
- Minimum write latency (NXT immediately high): grant cycle + 3 cycles to done.

Decomposition:
- Shared package ulpi_pkg:
  - TX CMD prefixes REGW=2'b10 and REGR=2'b11.
  - NOOP=8'h00.
  - State enum.
  - Request struct {we, addr[5:0], wdata[7:0]}.
- Sub-module ulpi_rr_arb: 2-way round-robin grant with pointer update, reused by later TX-packet scheduling.

Test Plan:
- A write addr 0x0A data 0x55, NXT high 1 cycle after TXCMD → o_data sequence 0x8A,0x55,0x00; STP high 1 cycle; o_a_done=1, o_err=0.
- B read addr 0x16, PHY: NXT, DIR rise, data 0xC3 → o_data 0xD6 then 0x00; o_rdata=0xC3 with o_b_done; no o_stp.
- A and B valid in the same cycle, twice in a row → grants A then B (RR_INIT=0); each ready is 1 cycle; no overlap of transactions.
- DIR asserted during WDATA of write 0x04/0x41, RX CMD 0x4E presented → o_rxcmd=0x4E pulse; after DIR low plus turnaround, TXCMD 0x84 reissued; completes with err=0.
- DIR forced high on every attempt (MAX_RETRY=3) → 4 attempts total, then done with err=1; arbiter returns to IDLE.
- i_rst_n low mid-WDATA → o_data=0, o_stp=0, busy=0 asynchronously; no done pulse; next request processes normally.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared ULPI link-side definitions: TX CMD prefixes, state encoding and the
// latched register-request record used by the register scheduler.
package ulpi_pkg;

    localparam logic [1:0] REGW = 2'b10;
    localparam logic [1:0] REGR = 2'b11;
    localparam logic [7:0] NOOP = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_TXCMD      = 4'd1,
        ST_WDATA      = 4'd2,
        ST_STP        = 4'd3,
        ST_RD_WAIT    = 4'd4,
        ST_RD_DATA    = 4'd5,
        ST_RD_END     = 4'd6,
        ST_RD_TURN    = 4'd7,
        ST_ABORT      = 4'd8,
        ST_ABORT_TURN = 4'd9
    } state_e;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } ulpi_req_t;

    function automatic logic [7:0] txcmd_byte(input ulpi_req_t r);
        return {(r.we ? REGW : REGR), r.addr};
    endfunction

endpackage

// File: rtl/ulpi_rr_arb.sv
// Two-way round-robin arbiter; after any grant the priority pointer moves to
// the requester that was not served.
module ulpi_rr_arb #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic ptr_q, ptr_d;   // 0: A has priority, 1: B has priority

    always_comb begin
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        ptr_d   = ptr_q;
        if (i_en) begin
            if (i_req_a && (!i_req_b || !ptr_q)) begin
                o_gnt_a = 1'b1;
                ptr_d   = 1'b1;
            end else if (i_req_b) begin
                o_gnt_b = 1'b1;
                ptr_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ptr_q <= (RR_INIT != 0);
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ulpi_reg_sched.sv
// ULPI register-access scheduler: arbitrates two requesters and sequences the
// TX CMD / data / STP or read turnaround on the shared bus, with abort retry.
module ulpi_reg_sched
    import ulpi_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RR_INIT   = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_dir,
    input  logic       i_nxt,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_stp,
    input  logic       i_a_valid,
    input  logic       i_a_we,
    input  logic [5:0] i_a_addr,
    input  logic [7:0] i_a_wdata,
    input  logic       i_b_valid,
    input  logic       i_b_we,
    input  logic [5:0] i_b_addr,
    input  logic [7:0] i_b_wdata,
    output logic       o_a_ready,
    output logic       o_b_ready,
    output logic       o_a_done,
    output logic       o_b_done,
    output logic [7:0] o_rdata,
    output logic       o_err,
    output logic       o_rxcmd_valid,
    output logic [7:0] o_rxcmd,
    output logic       o_busy
);

    state_e    state_q, state_d;
    ulpi_req_t req_q, req_d;
    logic      owner_q, owner_d;        // 0: A, 1: B
    logic [7:0] retry_q, retry_d;
    logic      done_q, done_d;
    logic      err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] rxcmd_q, rxcmd_d;
    logic      rxcmd_valid_q, rxcmd_valid_d;
    logic      dir_q, dir_d;
    logic      gnt_a, gnt_b;

    ulpi_rr_arb #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (state_q == ST_IDLE && !i_dir),
        .i_req_a (i_a_valid),
        .i_req_b (i_b_valid),
        .o_gnt_a (gnt_a),
        .o_gnt_b (gnt_b)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        owner_d       = owner_q;
        retry_d       = retry_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        rxcmd_d       = rxcmd_q;
        rxcmd_valid_d = 1'b0;
        dir_d         = i_dir;

        case (state_q)
            ST_IDLE: begin
                if (gnt_a || gnt_b) begin
                    req_d   = gnt_b ? ulpi_req_t'{i_b_we, i_b_addr, i_b_wdata}
                                    : ulpi_req_t'{i_a_we, i_a_addr, i_a_wdata};
                    owner_d = gnt_b;
                    retry_d = '0;
                    state_d = ST_TXCMD;
                end
            end
            ST_TXCMD: begin
                if (i_dir)      state_d = ST_ABORT;
                else if (i_nxt) state_d = req_q.we ? ST_WDATA : ST_RD_WAIT;
            end
            ST_WDATA: begin
                if (i_dir) begin
                    state_d = ST_ABORT;
                end else if (i_nxt) begin
                    // done is registered so it coincides with the STP cycle
                    done_d  = 1'b1;
                    state_d = ST_STP;
                end
            end
            ST_STP:     state_d = ST_IDLE;
            ST_RD_WAIT: if (i_dir) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (i_nxt) begin
                    state_d = ST_ABORT;
                end else begin
                    rdata_d = i_data;
                    done_d  = 1'b1;
                    state_d = ST_RD_END;
                end
            end
            ST_RD_END:  if (!i_dir) state_d = ST_RD_TURN;
            ST_RD_TURN: state_d = ST_IDLE;
            ST_ABORT:   if (!i_dir) state_d = ST_ABORT_TURN;
            ST_ABORT_TURN: begin
                if (32'(retry_q) < MAX_RETRY) begin
                    retry_d = retry_q + 8'd1;
                    state_d = ST_TXCMD;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // First DIR-high cycle is the turnaround; later NXT-low cycles are RX CMDs
        if (i_dir && dir_q && !i_nxt && state_q != ST_RD_DATA) begin
            rxcmd_d       = i_data;
            rxcmd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            owner_q       <= 1'b0;
            retry_q       <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            rxcmd_q       <= '0;
            rxcmd_valid_q <= 1'b0;
            dir_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            owner_q       <= owner_d;
            retry_q       <= retry_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            rxcmd_q       <= rxcmd_d;
            rxcmd_valid_q <= rxcmd_valid_d;
            dir_q         <= dir_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_TXCMD: o_data = txcmd_byte(req_q);
            ST_WDATA: o_data = req_q.wdata;
            default:  o_data = NOOP;
        endcase
    end

    assign o_stp         = (state_q == ST_STP) && !i_dir;
    assign o_a_ready     = gnt_a;
    assign o_b_ready     = gnt_b;
    assign o_a_done      = done_q && !owner_q;
    assign o_b_done      = done_q && owner_q;
    assign o_err         = err_q;
    assign o_rdata       = rdata_q;
    assign o_rxcmd       = rxcmd_q;
    assign o_rxcmd_valid = rxcmd_valid_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule
